// File: rtl/pellet_map.sv
// Per-tile pellet store: sweeps the maze wall ROM to fill pellets, clears them as Pac-Man eats.
// Optional POWER_PELLET_EN adds a power-pellet RAM with eaten_power / vga_power outputs.
module pellet_map #(
  parameter int NUM_TILES = 1200,
  parameter int INDEX_W   = 11,
  parameter int COUNT_W   = 11
`ifdef POWER_PELLET_EN
  ,
  parameter int PP0 = 81,
  parameter int PP1 = 118,
  parameter int PP2 = 1081,
  parameter int PP3 = 1118
`endif
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               refill,
  output logic [INDEX_W-1:0] init_index,
  input  logic               init_is_wall,
  input  logic               pacman_valid,
  input  logic [INDEX_W-1:0] pacman_index,
  input  logic [INDEX_W-1:0] vga_index,
  output logic               vga_pellet,
  output logic               eaten,
  output logic [COUNT_W-1:0] pellets_left,
  output logic               busy,
  output logic               level_clear,
`ifdef POWER_PELLET_EN
  output logic               eaten_power,
  output logic               vga_power,
`endif
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_DRAIN = 2'd1,
    S_RUN   = 2'd2,
    S_CLEAR = 2'd3
  } state_t;

  state_t             state, state_next;
  logic [INDEX_W-1:0] addr, addr_d;
  logic               sweep_v;
  logic               sweep_we;
  logic               open_tile;
  logic               s1_valid;
  logic [INDEX_W-1:0] s1_idx;
  logic               s1_bit;
  logic               fire;
  logic               mem_we;
  logic               mem_wdata;
  logic [INDEX_W-1:0] mem_waddr;
  logic               pellet_mem [NUM_TILES];

  // Handshake: pacman_valid is a one-cycle strobe with no back-pressure; each
  // accepted strobe in RUN enters stage 1 and resolves in stage 2 one cycle later.
  always_comb begin
    open_tile  = ~init_is_wall;
    sweep_we   = ((state == S_INIT) || (state == S_DRAIN)) && sweep_v;
    fire       = (state == S_RUN) && s1_valid && s1_bit && (pellets_left != '0);
    state_next = state;
    case (state)
      S_INIT:  if (addr == INDEX_W'(NUM_TILES - 1)) state_next = S_DRAIN;
      S_DRAIN: state_next = ((pellets_left == '0) && !open_tile) ? S_CLEAR : S_RUN;
      S_RUN:   if (fire && (pellets_left == COUNT_W'(1))) state_next = S_CLEAR;
      S_CLEAR: state_next = S_CLEAR;
      default: state_next = S_INIT;
    endcase
    if (refill) state_next = S_INIT;
    mem_we     = (sweep_we || fire) && !Reset;
    mem_waddr  = sweep_we ? addr_d : s1_idx;
    mem_wdata  = sweep_we ? open_tile : 1'b0;
    busy       = (state == S_INIT) || (state == S_DRAIN);
    init_index = (state == S_INIT) ? addr : '0;
    state_dbg  = state;
  end

  always_ff @(posedge Clk) begin
    if (Reset) state <= S_INIT;
    else       state <= state_next;
  end

  always_ff @(posedge Clk) begin
    if (mem_we) pellet_mem[mem_waddr] <= mem_wdata;
  end

`ifdef POWER_PELLET_EN
  logic power_mem [NUM_TILES];
  logic s1_pow;
  logic pp_hit;

  always_comb begin
    pp_hit = (addr_d == INDEX_W'(PP0)) || (addr_d == INDEX_W'(PP1)) ||
             (addr_d == INDEX_W'(PP2)) || (addr_d == INDEX_W'(PP3));
  end

  // Shares the pellet write port: the sweep marks power tiles, an eat always clears.
  always_ff @(posedge Clk) begin
    if (mem_we) power_mem[mem_waddr] <= sweep_we ? (open_tile && pp_hit) : 1'b0;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_pow      <= 1'b0;
      eaten_power <= 1'b0;
      vga_power   <= 1'b0;
    end else begin
      vga_power   <= power_mem[vga_index];
      eaten_power <= fire && s1_pow && !refill;
      s1_pow      <= power_mem[pacman_index] && !(fire && (s1_idx == pacman_index));
    end
  end
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      addr         <= '0;
      addr_d       <= '0;
      sweep_v      <= 1'b0;
      pellets_left <= '0;
      s1_valid     <= 1'b0;
      s1_idx       <= '0;
      s1_bit       <= 1'b0;
      eaten        <= 1'b0;
      vga_pellet   <= 1'b0;
      level_clear  <= 1'b0;
    end else begin
      vga_pellet  <= pellet_mem[vga_index];
      level_clear <= (state == S_CLEAR) && !refill;
      eaten       <= fire && !refill;
      if (refill) begin
        addr         <= '0;
        sweep_v      <= 1'b0;
        pellets_left <= '0;
        s1_valid     <= 1'b0;
      end else begin
        s1_valid <= (state == S_RUN) && pacman_valid;
        s1_idx   <= pacman_index;
        // Forward a same-cycle clear so a held strobe cannot eat the tile twice.
        s1_bit   <= pellet_mem[pacman_index] && !(fire && (s1_idx == pacman_index));
        sweep_v  <= (state == S_INIT);
        addr_d   <= addr;
        if (state == S_INIT) addr <= addr + INDEX_W'(1);
        if (sweep_we && open_tile) pellets_left <= pellets_left + COUNT_W'(1);
        else if (fire)             pellets_left <= pellets_left - COUNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pellet_map.sv
// Directed bench for pellet_map: wall ROM model, scoreboard queue of expected eat events.
module tb_pellet_map;
  localparam int W = 44;  // {cycle[31:0], pellets_left[10:0], power}

  logic        Clk = 1'b0;
  logic        Reset, refill, init_is_wall, pacman_valid;
  logic [10:0] pacman_index, vga_index, init_index, pellets_left;
  logic        vga_pellet, eaten, busy, level_clear;
  logic [1:0]  state_dbg;
`ifdef POWER_PELLET_EN
  logic        eaten_power, vga_power;
`endif

  pellet_map dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .refill       (refill),
    .init_index   (init_index),
    .init_is_wall (init_is_wall),
    .pacman_valid (pacman_valid),
    .pacman_index (pacman_index),
    .vga_index    (vga_index),
    .vga_pellet   (vga_pellet),
    .eaten        (eaten),
    .pellets_left (pellets_left),
    .busy         (busy),
    .level_clear  (level_clear),
`ifdef POWER_PELLET_EN
    .eaten_power  (eaten_power),
    .vga_power    (vga_power),
`endif
    .state_dbg    (state_dbg)
  );

  // Clock and cycle counter
  always #5 Clk = ~Clk;
  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // Wall ROM model with a 1-cycle registered read
  int wall_mode = 0;
  function automatic logic wall_of(input logic [10:0] idx);
    case (wall_mode)
      0:       return (idx < 11'd40) || (idx >= 11'd1160);
      1:       return idx != 11'd600;
      default: return 1'b1;
    endcase
  endfunction
  always @(posedge Clk) init_is_wall <= wall_of(init_index);

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every eaten pulse must match the oldest expected event
  always @(negedge Clk) begin
    logic [W-1:0] e;
    if (Reset === 1'b0 && eaten === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_eaten", W'(eaten), '0);
      end else begin
        e = exp_q.pop_front();
        check("eaten_cycle", W'(cyc), W'(e[43:12]));
        check("eaten_left", W'(pellets_left), W'(e[11:1]));
`ifdef POWER_PELLET_EN
        check("eaten_power", W'(eaten_power), W'(e[0]));
`endif
      end
    end
`ifdef POWER_PELLET_EN
    if (Reset === 1'b0 && eaten_power === 1'b1 && eaten !== 1'b1)
      check("stray_eaten_power", W'(eaten_power), '0);
`endif
  end

  // Driver tasks: inputs change 1 time unit after the rising edge
  task automatic next();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) next();
  endtask

  task automatic expect_eat(input logic [10:0] left, input logic pow);
    int t;
    t = cyc + 2;
    exp_q.push_back({t[31:0], left, pow});
  endtask

  task automatic strobe(input logic [10:0] idx, input int n);
    pacman_valid = 1'b1;
    pacman_index = idx;
    repeat (n) next();
    pacman_valid = 1'b0;
  endtask

  task automatic vga_check(input string name, input logic [10:0] idx, input logic exp);
    vga_index = idx;
    next();
    check(name, W'(vga_pellet), W'(exp));
  endtask

  task automatic do_refill();
    refill = 1'b1;
    next();
    refill = 1'b0;
  endtask

  // Counts busy cycles from the current cycle and verifies init_index steps 0..1199
  task automatic sweep(input string name, input logic [10:0] exp_left, input logic [1:0] exp_state);
    int cycles;
    int bad;
    cycles = 0;
    bad    = 0;
    @(negedge Clk);
    while (busy && cycles < 3000) begin
      if (cycles < 1200 && init_index != cycles[10:0]) bad++;
      cycles++;
      @(negedge Clk);
    end
    check({name, "_busy_cycles"}, W'(cycles), W'(1201));
    check({name, "_index_steps"}, W'(bad), '0);
    check({name, "_pellets_left"}, W'(pellets_left), W'(exp_left));
    check({name, "_state"}, W'(state_dbg), W'(exp_state));
  endtask

  initial begin
    int k;
    Reset        = 1'b1;
    refill       = 1'b0;
    pacman_valid = 1'b0;
    pacman_index = '0;
    vga_index    = '0;
    idle(3);
    Reset = 1'b0;
    check("rst_busy", W'(busy), W'(1));
    check("rst_left", W'(pellets_left), '0);
    check("rst_eaten", W'(eaten), '0);
    check("rst_level_clear", W'(level_clear), '0);
    check("rst_vga_pellet", W'(vga_pellet), '0);
    check("rst_init_index", W'(init_index), '0);
    check("rst_state", W'(state_dbg), '0);
    sweep("init", 11'd1120, 2'd2);
    next();
    check("run_level_clear", W'(level_clear), '0);

    vga_check("vga_open_43", 11'd43, 1'b1);
    vga_check("vga_wall_5", 11'd5, 1'b0);

    expect_eat(11'd1119, 1'b0);
    strobe(11'd41, 1);
    idle(3);
    vga_check("vga_eaten_41", 11'd41, 1'b0);

    expect_eat(11'd1118, 1'b0);
    strobe(11'd42, 5);
    idle(3);

    strobe(11'd5, 1);
    idle(3);
    check("wall_strobe_left", W'(pellets_left), W'(1118));

    expect_eat(11'd1117, 1'b0);
    pacman_valid = 1'b1;
    pacman_index = 11'd43;
    next();
    expect_eat(11'd1116, 1'b0);
    pacman_index = 11'd44;
    next();
    pacman_valid = 1'b0;
    idle(3);

    strobe(11'd41, 1);
    idle(3);
    check("reeat_left", W'(pellets_left), W'(1116));

    // Strobe in flight when refill arrives: no eaten pulse
    pacman_valid = 1'b1;
    pacman_index = 11'd45;
    next();
    pacman_valid = 1'b0;
    do_refill();
    check("refill_busy", W'(busy), W'(1));
    check("refill_left", W'(pellets_left), '0);

    k = 0;
    while (init_index != 11'd500 && k < 2000) begin
      next();
      k++;
    end
    check("reach_addr_500", W'(init_index), W'(500));
    do_refill();
    check("restart_index", W'(init_index), '0);
    sweep("resweep", 11'd1120, 2'd2);
    next();

`ifdef POWER_PELLET_EN
    vga_index = 11'd118;
    next();
    check("vga_power_118", W'(vga_power), W'(1));
`endif
    expect_eat(11'd1119, 1'b1);
    strobe(11'd81, 1);
    idle(3);

    // Single open tile: last pellet clears the level
    wall_mode = 1;
    do_refill();
    sweep("one_tile", 11'd1, 2'd2);
    next();
    expect_eat(11'd0, 1'b0);
    strobe(11'd600, 1);
    next();
    check("last_eat_level_clear", W'(level_clear), '0);
    check("last_eat_left", W'(pellets_left), '0);
    next();
    check("level_clear_next", W'(level_clear), W'(1));
    check("clear_state", W'(state_dbg), W'(3));
    strobe(11'd600, 2);
    strobe(11'd599, 1);
    idle(3);
    check("clear_ignores_left", W'(pellets_left), '0);
    check("clear_holds_state", W'(state_dbg), W'(3));
    vga_check("vga_600_empty", 11'd600, 1'b0);
    do_refill();
    check("clear_refill_busy", W'(busy), W'(1));
    sweep("refill_one", 11'd1, 2'd2);
    next();

    // All walls: sweep ends straight in CLEAR
    wall_mode = 2;
    do_refill();
    sweep("all_wall", 11'd0, 2'd3);
    next();
    check("all_wall_level_clear", W'(level_clear), W'(1));

    idle(5);
    check("queue_drained", W'(exp_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
